// File: rtl/sub_17bit_seq.sv
// Multi-cycle chunked subtractor: D = A - B - bin, `chunk` bits per BUSY cycle, valid/ready on both sides.
// Optional signed-overflow flag enabled by defining SUB_OVF_EN.
module sub_17bit_seq #(
    parameter int width = 17,
    parameter int chunk = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [width-1:0] A,
    input  logic [width-1:0] B,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [width-1:0] D,
    output logic             bout,
    output logic             ovf
);

    localparam int N     = (width + chunk - 1) / chunk;
    localparam int W     = N * chunk;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_reg, state_next;
    logic [W-1:0]     a_sh_reg, b_sh_reg, d_sh_reg;
    logic [W-1:0]     a_ext, b_ext, d_sh_next;
    logic [IDX_W-1:0] idx_reg;
    logic             carry_reg, bout_reg;
    logic [chunk:0]   c;
    logic [chunk-1:0] s;
    logic             last;

    // Operands are zero-padded to a whole number of chunks. A zero in A against
    // a zero in B (i.e. ~B = 1) passes the carry through unchanged, so the final
    // carry equals the carry out of bit width-1.
    always_comb begin
        a_ext = '0;
        b_ext = '0;
        a_ext[width-1:0] = A;
        b_ext[width-1:0] = B;
    end

    assign c[0] = carry_reg;

    genvar gi;
    generate
        for (gi = 0; gi < chunk; gi++) begin : g_rca
            assign s[gi]    = a_sh_reg[gi] ^ ~b_sh_reg[gi] ^ c[gi];
            assign c[gi+1]  = (a_sh_reg[gi] & ~b_sh_reg[gi]) |
                              (c[gi] & (a_sh_reg[gi] ^ ~b_sh_reg[gi]));
        end

        // Result slices enter at the top and walk down, so after N cycles the
        // difference sits aligned at bit 0.
        if (chunk == W) begin : g_single
            assign d_sh_next = s;
        end else begin : g_multi
            assign d_sh_next = {s, d_sh_reg[W-1:chunk]};
        end
    endgenerate

    assign last = (idx_reg == IDX_W'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid)  state_next = BUSY;
            BUSY:    if (last)      state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_reg  <= '0;
            b_sh_reg  <= '0;
            d_sh_reg  <= '0;
            idx_reg   <= '0;
            carry_reg <= 1'b0;
            bout_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_sh_reg  <= a_ext;
                        b_sh_reg  <= b_ext;
                        carry_reg <= ~bin;
                        idx_reg   <= '0;
                    end
                end
                BUSY: begin
                    a_sh_reg  <= a_sh_reg >> chunk;
                    b_sh_reg  <= b_sh_reg >> chunk;
                    d_sh_reg  <= d_sh_next;
                    carry_reg <= c[chunk];
                    idx_reg   <= idx_reg + 1'b1;
                    if (last) begin
                        bout_reg <= ~c[chunk];
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SUB_OVF_EN
    logic a_msb_reg, b_msb_reg, ovf_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb_reg <= 1'b0;
            b_msb_reg <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            if (state_reg == IDLE && in_valid) begin
                a_msb_reg <= A[width-1];
                b_msb_reg <= B[width-1];
            end
            if (state_reg == BUSY && last) begin
                ovf_reg <= (a_msb_reg ^ b_msb_reg) & (d_sh_next[width-1] ^ a_msb_reg);
            end
        end
    end

    assign ovf = ovf_reg;
`else
    assign ovf = 1'b0;
`endif

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign D         = d_sh_reg[width-1:0];
    assign bout      = bout_reg;

endmodule

// File: tb/tb_sub_17bit_seq.sv
// Self-checking bench for sub_17bit_seq: directed vectors, backpressure, mid-op reset,
// overflow flag (follows SUB_OVF_EN) and randomized handshakes against an arithmetic model.
module tb_sub_17bit_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [16:0] A;
    logic [16:0] B;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] D;
    logic        bout;
    logic        ovf;

    int pass_cnt  = 0;
    int check_cnt = 0;

    sub_17bit_seq #(.width(17), .chunk(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
        .bout      (bout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Golden result {ovf, bout, D} from plain integer subtraction.
    function automatic logic [18:0] gold(input logic [16:0] a, input logic [16:0] b, input logic bi);
        logic [17:0] r;
        logic        o;
        r = {1'b0, a} - {1'b0, b} - {17'd0, bi};
        o = 1'b0;
`ifdef SUB_OVF_EN
        o = (a[16] != b[16]) && (r[16] != a[16]);
`endif
        return {o, r[17], r[16:0]};
    endfunction

    // Drive one operation, wait for the result, capture it, then consume it.
    task automatic run_op(input logic [16:0] a, input logic [16:0] b, input logic bi,
                          output logic [18:0] res, output int lat, output bit ok);
        bit acc;
        int n;
        ok = 1'b1;
        in_valid = 1'b1; A = a; B = b; bin = bi;
        n = 0;
        do begin
            acc = in_ready;
            @(posedge clk); #1;
            n++;
        end while (!acc && n < 100);
        in_valid = 1'b0; A = 17'($urandom); B = 17'($urandom); bin = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!acc || !out_valid) begin
            ok = 1'b0;
            check_cnt++;
            $display("FAIL handshake_timeout a=%h b=%h: accepted=%0b out_valid=%0b, required both 1", a, b, acc, out_valid);
        end
        res = {ovf, bout, D};
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; bin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_cnt++;
        if ({out_valid, D, bout, ovf} !== 20'd0)
            $display("FAIL reset_outputs: out_valid=%0b D=%h bout=%0b ovf=%0b, required all 0", out_valid, D, bout, ovf);
        else pass_cnt++;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b, required 1", in_ready);
        else pass_cnt++;
        $display("reset: out_valid=%0b D=%h in_ready=%0b", out_valid, D, in_ready);
    endtask

    task automatic test_directed;
        logic [16:0] va [3] = '{17'h1FFFF, 17'h00000, 17'd5};
        logic [16:0] vb [3] = '{17'h00001, 17'h00001, 17'd5};
        logic        vc [3] = '{1'b0, 1'b0, 1'b1};
        logic [17:0] req [3] = '{{1'b0, 17'h1FFFE}, {1'b1, 17'h1FFFF}, {1'b1, 17'h1FFFF}};
        logic [18:0] res;
        int lat;
        bit ok;
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], vc[i], res, lat, ok);
            check_cnt++;
            if (res[17:0] !== req[i])
                $display("FAIL directed_%0d: {bout,D}=%h, required %h", i, res[17:0], req[i]);
            else pass_cnt++;
            if (i == 0) begin
                check_cnt++;
                if (lat !== 5) $display("FAIL latency: got %0d cycles, required 5", lat);
                else pass_cnt++;
            end
            $display("directed %0d: A=%h B=%h bin=%0b -> D=%h bout=%0b lat=%0d", i, va[i], vb[i], vc[i], res[16:0], res[17], lat);
        end
    endtask

    task automatic test_backpressure;
        int n;
        bit bad;
        in_valid = 1'b1; A = 17'h00100; B = 17'h00010; bin = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0; A = '1; B = '0; bin = 1'b1;
        n = 0;
        while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check_cnt++;
            if (D !== 17'h000F0 || bout !== 1'b0 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                $display("FAIL backpressure_hold_%0d: D=%h bout=%0b out_valid=%0b in_ready=%0b, required D=000f0 bout=0 out_valid=1 in_ready=0",
                         i, D, bout, out_valid, in_ready);
                bad = 1'b1;
            end else pass_cnt++;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL backpressure_release: in_ready=%0b out_valid=%0b, required 1 and 0", in_ready, out_valid);
        else pass_cnt++;
        $display("backpressure: D=000f0 held 10 cycles, errors=%0b", bad);
    endtask

    task automatic test_reset_midop;
        logic [18:0] res;
        int lat;
        bit ok;
        in_valid = 1'b1; A = 17'h1ABCD; B = 17'h01234; bin = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_cnt++;
        if ({out_valid, D, bout, ovf} !== 20'd0 || in_ready !== 1'b1)
            $display("FAIL midop_reset: out_valid=%0b D=%h bout=%0b ovf=%0b in_ready=%0b, required 0/0/0/0/1",
                     out_valid, D, bout, ovf, in_ready);
        else pass_cnt++;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL midop_idle: out_valid=%0b in_ready=%0b, required 0 and 1", out_valid, in_ready);
        else pass_cnt++;
        run_op(17'd7, 17'd2, 1'b0, res, lat, ok);
        check_cnt++;
        if (res[17:0] !== {1'b0, 17'd5})
            $display("FAIL after_reset_op: {bout,D}=%h, required 00005", res[17:0]);
        else pass_cnt++;
        $display("midop reset: then 7-2 -> D=%h bout=%0b", res[16:0], res[17]);
    endtask

    task automatic test_ovf;
        logic [18:0] res;
        logic        req_ovf;
        int lat;
        bit ok;
`ifdef SUB_OVF_EN
        req_ovf = 1'b1;
`else
        req_ovf = 1'b0;
`endif
        run_op(17'h0FFFF, 17'h1FFFF, 1'b0, res, lat, ok);
        check_cnt++;
        if (res !== {req_ovf, 1'b1, 17'h10000})
            $display("FAIL ovf_set: {ovf,bout,D}=%h, required %h", res, {req_ovf, 1'b1, 17'h10000});
        else pass_cnt++;
        $display("ovf: 0ffff-1ffff -> D=%h bout=%0b ovf=%0b", res[16:0], res[17], res[18]);
        run_op(17'd3, 17'd1, 1'b0, res, lat, ok);
        check_cnt++;
        if (res !== {1'b0, 1'b0, 17'd2})
            $display("FAIL ovf_clear: {ovf,bout,D}=%h, required 00002", res);
        else pass_cnt++;
        $display("ovf: 3-1 -> D=%h bout=%0b ovf=%0b", res[16:0], res[17], res[18]);
    endtask

    task automatic test_random;
        logic [50:0] q[$];
        logic [50:0] cur;
        logic [18:0] req;
        bit pending, acc, deq;
        int sent, got;
        pending = 1'b0; sent = 0; got = 0; cur = '0;
        for (int cyc = 0; cyc < 4000 && got < 50; cyc++) begin
            if (!pending && sent < 50 && $urandom_range(1, 0) == 1) begin
                cur = {17'($urandom), 17'($urandom), 1'($urandom), 16'(sent)};
                pending = 1'b1;
            end
            if (pending) begin
                A = cur[50:34]; B = cur[33:17]; bin = cur[16];
                in_valid = 1'($urandom);
            end else begin
                A = 17'($urandom); B = 17'($urandom); bin = 1'($urandom);
                in_valid = 1'b0;
            end
            out_ready = 1'($urandom);
            acc = in_valid && in_ready;
            deq = out_valid && out_ready;
            if (deq) begin
                check_cnt++;
                if (q.size() == 0) begin
                    $display("FAIL random_extra: result D=%h bout=%0b with no operation outstanding", D, bout);
                end else begin
                    cur = q.pop_front();
                    req = gold(cur[50:34], cur[33:17], cur[16]);
                    if ({ovf, bout, D} !== req)
                        $display("FAIL random_%0d: A=%h B=%h bin=%0b {ovf,bout,D}=%h, required %h",
                                 cur[15:0], cur[50:34], cur[33:17], cur[16], {ovf, bout, D}, req);
                    else pass_cnt++;
                    $display("random %0d: A=%h B=%h bin=%0b -> D=%h bout=%0b", cur[15:0], cur[50:34], cur[33:17], cur[16], D, bout);
                    got++;
                end
                if (pending) cur = {A, B, bin, 16'(sent)};
            end
            @(posedge clk); #1;
            if (acc) begin
                q.push_back({A, B, bin, 16'(sent)});
                pending = 1'b0;
                sent++;
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check_cnt++;
        if (got !== 50 || q.size() !== 0)
            $display("FAIL random_count: results=%0d outstanding=%0d, required 50 and 0", got, q.size());
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_midop();
        test_ovf();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
